// File: rtl/sine_pwm_pkg.sv
// Shared types and constants for the sine-PWM command path and datapath:
// controller states, ASCII command/ack bytes and the preset divider table.
package sine_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIGITS,
        ST_APPLY_WAIT,
        ST_ACK
    } state_t;

    localparam logic [7:0] ACK_OK  = 8'h4B;
    localparam logic [7:0] ACK_ERR = 8'h45;
    localparam logic [7:0] CMD_F   = 8'h46;
    localparam logic [7:0] CMD_G   = 8'h47;
    localparam logic [7:0] CMD_S   = 8'h53;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_1 = 8'h31;
    localparam logic [7:0] ASCII_7 = 8'h37;
    localparam logic [7:0] ASCII_9 = 8'h39;

    // Presets '1'..'7' are selected by the low three bits of the ASCII code.
    function automatic int unsigned preset_div(input logic [2:0] sel);
        case (sel)
            3'd1:    preset_div = 1600;
            3'd2:    preset_div = 825;
            3'd3:    preset_div = 556;
            3'd4:    preset_div = 415;
            3'd5:    preset_div = 333;
            3'd6:    preset_div = 276;
            3'd7:    preset_div = 237;
            default: preset_div = 1600;
        endcase
    endfunction

endpackage

// File: rtl/sine_cmd_dec_acc.sv
// Decimal accumulator for the 'F' command: ASCII digit detect, acc*10+digit,
// digit count and the accepted-range check on the accumulated value.
module sine_cmd_dec_acc
    import sine_pwm_pkg::*;
#(
    parameter int DIV_W   = 14,
    parameter int DIV_MIN = 200,
    parameter int DIV_MAX = 9999
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [7:0]       data,
    output logic             is_digit,
    output logic [DIV_W-1:0] acc,
    output logic             cnt_zero,
    output logic             cnt_full,
    output logic             in_range
);

    logic [2:0] cnt;
    logic [3:0] digit;

    // For '0'..'9' the low nibble of the ASCII code is the digit value.
    assign digit    = data[3:0];
    assign is_digit = (data >= ASCII_0) && (data <= ASCII_9);
    assign cnt_zero = (cnt == 3'd0);
    assign cnt_full = (cnt == 3'd4);
    assign in_range = (acc >= DIV_W'(DIV_MIN)) && (acc <= DIV_W'(DIV_MAX));

    always_ff @(posedge clk1) begin
        if (rst || clear) begin
            acc <= '0;
            cnt <= 3'd0;
        end else if (push) begin
            acc <= (acc << 3) + (acc << 1) + DIV_W'(digit);
            cnt <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/sine_pwm_cmd_ctrl.sv
// UART command controller for the sine-PWM datapath: parses commands, defers
// divider updates to a waveform-period boundary, and acks each command on TX.
module sine_pwm_cmd_ctrl
    import sine_pwm_pkg::*;
#(
    parameter int DIV_W       = 14,
    parameter int DIV_DEFAULT = 1600,
    parameter int DIV_MIN     = 200,
    parameter int DIV_MAX     = 9999,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_break,
    input  logic             tx_busy,
    output logic             tx_en,
    output logic [7:0]       tx_data,
    input  logic             cycle_wrap,
    output logic [DIV_W-1:0] div_out,
    output logic             div_load,
    output logic             pwm_run,
    output logic             cmd_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);

    state_t           state;
    logic [DIV_W-1:0] pending;
    logic [TO_W-1:0]  to_cnt;
    logic [DIV_W-1:0] acc;
    logic             is_digit, cnt_zero, cnt_full, in_range;
    logic             acc_clear, acc_push;

    assign acc_clear = (state == ST_IDLE) && rx_valid && !rx_break && (rx_data == CMD_F);
    assign acc_push  = (state == ST_DIGITS) && rx_valid && !rx_break && is_digit && !cnt_full;

    sine_cmd_dec_acc #(
        .DIV_W  (DIV_W),
        .DIV_MIN(DIV_MIN),
        .DIV_MAX(DIV_MAX)
    ) u_dec_acc (
        .clk1    (clk1),
        .rst     (rst),
        .clear   (acc_clear),
        .push    (acc_push),
        .data    (rx_data),
        .is_digit(is_digit),
        .acc     (acc),
        .cnt_zero(cnt_zero),
        .cnt_full(cnt_full),
        .in_range(in_range)
    );

    // Entering ACK with tx_busy already low raises tx_en on the entry edge.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state    <= ST_IDLE;
            pending  <= '0;
            to_cnt   <= '0;
            div_out  <= DIV_W'(DIV_DEFAULT);
            div_load <= 1'b0;
            pwm_run  <= 1'b0;
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
            cmd_err  <= 1'b0;
        end else begin
            div_load <= 1'b0;
            cmd_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_break && rx_valid) begin
                        if (rx_data >= ASCII_1 && rx_data <= ASCII_7) begin
                            pending <= DIV_W'(preset_div(rx_data[2:0]));
                            state   <= ST_APPLY_WAIT;
                        end else if (rx_data == CMD_F) begin
                            to_cnt <= '0;
                            state  <= ST_DIGITS;
                        end else if (rx_data == CMD_G || rx_data == CMD_S) begin
                            pwm_run <= (rx_data == CMD_G);
                            tx_data <= ACK_OK;
                            tx_en   <= !tx_busy;
                            state   <= ST_ACK;
                        end else if (rx_data != CR && rx_data != LF) begin
                            cmd_err <= 1'b1;
                            tx_data <= ACK_ERR;
                            tx_en   <= !tx_busy;
                            state   <= ST_ACK;
                        end
                    end
                end
                ST_DIGITS: begin
                    if (rx_break) begin
                        state <= ST_IDLE;
                    end else if (rx_valid) begin
                        if (is_digit && !cnt_full) begin
                            to_cnt <= '0;
                        end else if (rx_data == CR && !cnt_zero && in_range) begin
                            pending <= acc;
                            state   <= ST_APPLY_WAIT;
                        end else begin
                            cmd_err <= 1'b1;
                            tx_data <= ACK_ERR;
                            tx_en   <= !tx_busy;
                            state   <= ST_ACK;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        cmd_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_APPLY_WAIT: begin
                    if (rx_break) begin
                        state <= ST_IDLE;
                    end else begin
                        cmd_err <= rx_valid;
                        // A stopped datapath has no period to protect.
                        if (!pwm_run || cycle_wrap) begin
                            div_out  <= pending;
                            div_load <= 1'b1;
                            tx_data  <= ACK_OK;
                            tx_en    <= !tx_busy;
                            state    <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    cmd_err <= rx_valid;
                    if (tx_en) begin
                        tx_en <= 1'b0;
                        state <= ST_IDLE;
                    end else if (!tx_busy) begin
                        tx_en <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_pwm_cmd_ctrl.sv
// Self-checking bench for sine_pwm_cmd_ctrl: a command vector table plus
// hand-written sequences for period-boundary apply, timeout, busy TX, break and reset.
module tb_sine_pwm_cmd_ctrl;

    localparam int T_CYC = 300;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_break = 1'b0;
    logic        tx_busy = 1'b0;
    logic        cycle_wrap = 1'b0;
    logic        tx_en, div_load, pwm_run, cmd_err;
    logic [7:0]  tx_data;
    logic [13:0] div_out;

    sine_pwm_cmd_ctrl #(.TIMEOUT_CYC(T_CYC)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_break  (rx_break),
        .tx_busy   (tx_busy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .cycle_wrap(cycle_wrap),
        .div_out   (div_out),
        .div_load  (div_load),
        .pwm_run   (pwm_run),
        .cmd_err   (cmd_err)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int failures = 0;
    int tx_cnt = 0;
    int load_cnt = 0;
    int err_cnt = 0;
    logic [7:0]  exp_tx_q[$];
    logic [13:0] exp_div_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard: every tx_en / div_load pops the oldest expected value.
    always @(negedge clk1) begin
        if (!rst) begin
            if (tx_en) begin
                tx_cnt++;
                if (exp_tx_q.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF);
                else check("tx_data", 32'(tx_data), 32'(exp_tx_q.pop_front()));
            end
            if (div_load) begin
                load_cnt++;
                if (exp_div_q.size() == 0) check("load_unexpected", 32'(div_out), 32'hFFFF);
                else check("div_out_at_load", 32'(div_out), 32'(exp_div_q.pop_front()));
            end
            if (cmd_err) err_cnt++;
        end
    end

    typedef struct {
        logic [5:0][7:0] b;
        int              n;
        bit              ack;
        logic [7:0]      ack_b;
        bit              ld;
        logic [13:0]     div;
        int              errs;
    } vec_t;

    function automatic vec_t mk(input string s, input bit ack, input logic [7:0] ab,
                                input bit ld, input logic [13:0] d, input int e);
        vec_t v;
        v.b = '0;
        v.n = s.len();
        for (int i = 0; i < s.len(); i++) v.b[i] = s[i];
        v.ack = ack;
        v.ack_b = ab;
        v.ld = ld;
        v.div = d;
        v.errs = e;
        return v;
    endfunction

    // Called at a negedge; the byte is sampled by the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        @(negedge clk1);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    vec_t        vecs[15];
    logic [13:0] cur_div;
    int          tx0, ld0, er0, n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk("3",          1, 8'h4B, 1, 556, 0);
        vecs[1]  = mk("1",          1, 8'h4B, 1, 1600, 0);
        vecs[2]  = mk("7",          1, 8'h4B, 1, 237, 0);
        vecs[3]  = mk("F1000\015",  1, 8'h4B, 1, 1000, 0);
        vecs[4]  = mk("F200\015",   1, 8'h4B, 1, 200, 0);
        vecs[5]  = mk("F9999\015",  1, 8'h4B, 1, 9999, 0);
        vecs[6]  = mk("F0150\015",  1, 8'h45, 0, 0, 1);
        vecs[7]  = mk("F199\015",   1, 8'h45, 0, 0, 1);
        vecs[8]  = mk("F12345",     1, 8'h45, 0, 0, 1);
        vecs[9]  = mk("F\015",      1, 8'h45, 0, 0, 1);
        vecs[10] = mk("X",          1, 8'h45, 0, 0, 1);
        vecs[11] = mk("F12A",       1, 8'h45, 0, 0, 1);
        vecs[12] = mk("\n",         0, 8'h00, 0, 0, 0);
        vecs[13] = mk("S",          1, 8'h4B, 0, 0, 0);
        vecs[14] = mk("F0200\015",  1, 8'h4B, 1, 200, 0);

        // Reset state
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        rst = 1'b0;
        cur_div = 14'd1600;
        check("rst_div_out", 32'(div_out), 32'd1600);
        check("rst_pwm_run", 32'(pwm_run), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_div_load", 32'(div_load), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);

        // Vector table, datapath stopped so updates apply immediately
        foreach (vecs[i]) begin
            tx0 = tx_cnt; ld0 = load_cnt; er0 = err_cnt;
            if (vecs[i].ack) exp_tx_q.push_back(vecs[i].ack_b);
            if (vecs[i].ld) begin
                exp_div_q.push_back(vecs[i].div);
                cur_div = vecs[i].div;
            end
            for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k]);
            repeat (8) @(negedge clk1);
            check($sformatf("vec%0d_acks", i), 32'(tx_cnt - tx0), 32'(vecs[i].ack));
            check($sformatf("vec%0d_loads", i), 32'(load_cnt - ld0), 32'(vecs[i].ld));
            check($sformatf("vec%0d_errs", i), 32'(err_cnt - er0), 32'(vecs[i].errs));
            check($sformatf("vec%0d_div_out", i), 32'(div_out), 32'(cur_div));
        end

        // Running datapath: divider held until the period wraps
        exp_tx_q.push_back(8'h4B);
        send_byte(8'h47);
        repeat (4) @(negedge clk1);
        check("g_pwm_run", 32'(pwm_run), 32'd1);
        ld0 = load_cnt; tx0 = tx_cnt;
        exp_tx_q.push_back(8'h4B);
        exp_div_q.push_back(14'd1000);
        send_str("F1000\015");
        repeat (20) @(negedge clk1);
        check("wait_no_load", 32'(load_cnt - ld0), 32'd0);
        check("wait_div_held", 32'(div_out), 32'(cur_div));
        check("wait_no_ack", 32'(tx_cnt - tx0), 32'd0);
        cycle_wrap = 1'b1;
        @(negedge clk1);
        cycle_wrap = 1'b0;
        check("wrap_div_load", 32'(div_load), 32'd1);
        check("wrap_div_out", 32'(div_out), 32'd1000);
        cur_div = 14'd1000;
        repeat (4) @(negedge clk1);
        check("wrap_ack", 32'(tx_cnt - tx0), 32'd1);

        // Wrap and a stray byte in the same cycle
        exp_tx_q.push_back(8'h4B);
        exp_div_q.push_back(14'd2000);
        send_str("F2000\015");
        repeat (5) @(negedge clk1);
        er0 = err_cnt;
        cycle_wrap = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h51;
        @(negedge clk1);
        cycle_wrap = 1'b0;
        rx_valid = 1'b0;
        check("simul_div_load", 32'(div_load), 32'd1);
        check("simul_cmd_err", 32'(cmd_err), 32'd1);
        check("simul_div_out", 32'(div_out), 32'd2000);
        cur_div = 14'd2000;
        repeat (4) @(negedge clk1);
        exp_tx_q.push_back(8'h4B);
        send_byte(8'h53);
        repeat (4) @(negedge clk1);
        check("s_pwm_run", 32'(pwm_run), 32'd0);

        // Inter-byte timeout
        tx0 = tx_cnt;
        send_str("F1");
        n = 0;
        while (n < T_CYC + 50) begin
            @(negedge clk1);
            n++;
            if (cmd_err) break;
        end
        check("timeout_seen", 32'(n >= T_CYC - 2 && n <= T_CYC + 2), 32'd1);
        repeat (4) @(negedge clk1);
        check("timeout_no_ack", 32'(tx_cnt - tx0), 32'd0);
        exp_tx_q.push_back(8'h4B);
        exp_div_q.push_back(14'd825);
        send_byte(8'h32);
        repeat (8) @(negedge clk1);
        cur_div = 14'd825;
        check("after_timeout_div", 32'(div_out), 32'd825);

        // TX busy holds the ack; byte arriving in ACK is dropped
        tx_busy = 1'b1;
        tx0 = tx_cnt; er0 = err_cnt;
        exp_tx_q.push_back(8'h4B);
        send_byte(8'h53);
        repeat (250) @(negedge clk1);
        send_byte(8'h5A);
        repeat (250) @(negedge clk1);
        check("busy_no_tx", 32'(tx_cnt - tx0), 32'd0);
        check("busy_drop_err", 32'(err_cnt - er0), 32'd1);
        tx_busy = 1'b0;
        repeat (5) @(negedge clk1);
        check("busy_tx_after", 32'(tx_cnt - tx0), 32'd1);

        // Break mid-command
        tx0 = tx_cnt; er0 = err_cnt; ld0 = load_cnt;
        send_str("F12");
        rx_break = 1'b1;
        @(negedge clk1);
        rx_break = 1'b0;
        repeat (6) @(negedge clk1);
        check("break_no_ack", 32'(tx_cnt - tx0), 32'd0);
        check("break_no_load", 32'(load_cnt - ld0), 32'd0);
        check("break_div_held", 32'(div_out), 32'(cur_div));
        exp_tx_q.push_back(8'h4B);
        exp_div_q.push_back(14'd333);
        send_byte(8'h35);
        repeat (8) @(negedge clk1);
        check("after_break_div", 32'(div_out), 32'd333);

        // Reset while waiting for the period boundary
        exp_tx_q.push_back(8'h4B);
        send_byte(8'h47);
        repeat (6) @(negedge clk1);
        tx0 = tx_cnt; ld0 = load_cnt;
        send_str("F3000\015");
        repeat (5) @(negedge clk1);
        rst = 1'b1;
        repeat (2) @(negedge clk1);
        rst = 1'b0;
        @(negedge clk1);
        check("rst2_div_out", 32'(div_out), 32'd1600);
        check("rst2_pwm_run", 32'(pwm_run), 32'd0);
        repeat (10) @(negedge clk1);
        check("rst2_no_ack", 32'(tx_cnt - tx0), 32'd0);
        check("rst2_no_load", 32'(load_cnt - ld0), 32'd0);

        check("exp_tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
        check("exp_div_q_empty", 32'(exp_div_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
